// File: rtl/program_loader_if.sv
// Purpose : bundles the loader's control, byte-stream, fetch-path and instruction-memory signals.
// Ports   : slave = the loader's view; master = the environment (program source, CPU, memory).
// Notes   : ADDR_WIDTH must match the loader instance it is connected to.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 20
);
    // load control
    logic                  start;
    logic [ADDR_WIDTH-1:0] word_count;
    logic                  busy;
    logic                  done;
    logic                  error;
    // byte stream
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    // processor fetch path
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [31:0]           cpu_instruction;
    logic                  cpu_stall;
    // single-port instruction memory
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_wdata;
    logic                  mem_we;
    logic [31:0]           mem_rdata;

    modport slave (
        input  start, word_count, byte_valid, byte_data, cpu_address, mem_rdata,
        output busy, done, error, byte_ready, cpu_instruction, cpu_stall,
               mem_address, mem_wdata, mem_we
    );

    modport master (
        output start, word_count, byte_valid, byte_data, cpu_address, mem_rdata,
        input  busy, done, error, byte_ready, cpu_instruction, cpu_stall,
               mem_address, mem_wdata, mem_we
    );
endinterface

// File: rtl/program_loader.sv
// Purpose : arbitrates the instruction memory between fetch and a byte-wide load stream,
//           packing big-endian bytes into 32-bit words written from address 0 upwards.
// Latency : start in cycle N -> byte_ready in N+1; each word costs >= 5 cycles (4 bytes + WRITE);
//           done in N+1+5k for k words with continuous bytes (+1 with the checksum byte).
// Backpr. : byte_ready only in COLLECT (and CHECK); byte_valid low simply stalls, no timeout.
// Ports   : clock, reset_n (async, active low); bus = program_loader_if.slave.
// Config  : define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module program_loader #(
    parameter int ADDR_WIDTH = 20,
    parameter int SIZE       = 110
) (
    input  logic             clock,
    input  logic             reset_n,
    program_loader_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] SIZE_W = ADDR_WIDTH'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] ONE_W  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_FINISH  = 3'd3
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CHECK   = 3'd4
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           word_q, word_d;
    logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  byte_ready_c;
    logic                  byte_hs;
    logic [ADDR_WIDTH-1:0] ptr_next;

`ifdef LOADER_CHECKSUM_EN
    assign byte_ready_c = (state_q == S_COLLECT) || (state_q == S_CHECK);
`else
    assign byte_ready_c = (state_q == S_COLLECT);
`endif
    assign byte_hs  = byte_ready_c && bus.byte_valid;
    assign ptr_next = ptr_q + ONE_W;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if ((bus.word_count == '0) || (bus.word_count > SIZE_W)) begin
                        error_d = 1'b1;
                    end else begin
                        error_d    = 1'b0;
                        count_d    = bus.word_count;
                        ptr_d      = '0;
                        byte_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = '0;
`endif
                        state_d    = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (byte_hs) begin
                    // shift left so the first byte of a word ends up in [31:24]
                    word_d     = {word_q[23:0], bus.byte_data};
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.byte_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                ptr_d      = ptr_next;
                byte_idx_d = '0;
                if (ptr_next == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_FINISH;
`endif
                end else begin
                    state_d = S_COLLECT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (byte_hs) begin
                    if (bus.byte_data == csum_q) begin
                        state_d = S_FINISH;
                    end else begin
                        // memory keeps what was written; only the done pulse is withheld
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // the fetch path owns the address only in IDLE; otherwise the load pointer drives it
    assign bus.mem_address     = (state_q == S_IDLE) ? bus.cpu_address : ptr_q;
    assign bus.mem_wdata       = word_q;
    assign bus.mem_we          = (state_q == S_WRITE);
    assign bus.byte_ready      = byte_ready_c;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.cpu_stall       = (state_q != S_IDLE);
    assign bus.done            = (state_q == S_FINISH);
    assign bus.error           = error_q;
    assign bus.cpu_instruction = bus.mem_rdata;

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;
    localparam int AW   = 20;
    localparam int SIZE = 110;
`ifdef LOADER_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_loader #(.ADDR_WIDTH(AW), .SIZE(SIZE)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    // memory and observation logs
    logic [31:0] mem [0:127];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  acc_q[$];
    int          rdy_in_write = 0;

    assign bus.mem_rdata = mem[bus.mem_address[6:0]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_address[6:0]] <= bus.mem_wdata;
            wr_addr_q.push_back(int'(bus.mem_address));
            wr_data_q.push_back(bus.mem_wdata);
            if (bus.byte_ready) rdy_in_write++;
        end
        if (bus.byte_valid && bus.byte_ready) acc_q.push_back(bus.byte_data);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [7:0] stim[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        acc_q.delete();
    endtask

    // reference: the trailing checksum byte is the XOR of every data byte
    task automatic add_csum();
        logic [7:0] x;
        x = 8'h00;
        foreach (stim[i]) x ^= stim[i];
        if (CSUM == 1) stim.push_back(x);
    endtask

    task automatic gen_stim(input int k);
        stim.delete();
        for (int i = 0; i < 4 * k; i++) stim.push_back(8'($urandom));
        add_csum();
    endtask

    function automatic logic [31:0] exp_word(input int i);
        return {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
    endfunction

    task automatic start_load(input int k, output int n0);
        n0 = cyc;
        bus.start      = 1'b1;
        bus.word_count = AW'(k);
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            int w;
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            bus.byte_valid = 1'b0;
            repeat (g) tick();
            bus.byte_valid = 1'b1;
            bus.byte_data  = stim[i];
            w = 0;
            while (!bus.byte_ready && w < 100) begin
                tick();
                w++;
            end
            if (w >= 100) begin
                check("byte_handshake_timeout", 1, 0);
                bus.byte_valid = 1'b0;
                return;
            end
            tick();
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc, output bit seen);
        seen = 1'b0;
        dc   = -1;
        for (int i = 0; i < 60; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                dc   = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic verify_writes(input int k);
        int bad;
        int n;
        check("wr_count", wr_addr_q.size(), k);
        n = (wr_addr_q.size() < k) ? wr_addr_q.size() : k;
        for (int i = 0; i < n; i++) begin
            check("wr_addr", wr_addr_q[i], i);
            check("wr_data", wr_data_q[i], exp_word(i));
        end
        check("acc_count", acc_q.size(), stim.size());
        bad = 0;
        foreach (acc_q[i]) if (i < stim.size() && acc_q[i] !== stim[i]) bad++;
        check("acc_bytes", bad, 0);
    endtask

    task automatic finish_load(input int k, input int n0, input int gap_max, input bit chk_time);
        int dc;
        bit seen;
        send_bytes(stim.size(), gap_max);
        wait_done(dc, seen);
        check("done_seen", seen, 1);
        if (chk_time) check("done_cycle", dc - n0, 1 + 5 * k + CSUM);
        check("stall_at_done", bus.cpu_stall, 1);
        tick();
        check("done_width", bus.done, 0);
        check("stall_after_done", bus.cpu_stall, 0);
        check("busy_after_done", bus.busy, 0);
        verify_writes(k);
    endtask

    task automatic readback(input int k);
        int i;
        i = int'($urandom_range(k - 1, 0));
        bus.cpu_address = AW'(i);
        #1;
        check("fetch_addr_mux", bus.mem_address, i);
        check("fetch_data", bus.cpu_instruction, exp_word(i));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, bus.byte_ready, 0);
        check({tag, "_mem_we"},     bus.mem_we, 0);
        check({tag, "_mem_wdata"},  bus.mem_wdata, 0);
        check({tag, "_cpu_stall"},  bus.cpu_stall, 0);
        check({tag, "_busy"},       bus.busy, 0);
        check({tag, "_done"},       bus.done, 0);
        check({tag, "_error"},      bus.error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int k;
        bus.start       = 1'b0;
        bus.word_count  = '0;
        bus.byte_valid  = 1'b0;
        bus.byte_data   = '0;
        bus.cpu_address = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;
        tick();

        // single word, back-to-back bytes
        clear_logs();
        stim.delete();
        stim.push_back(8'h20); stim.push_back(8'hA0); stim.push_back(8'h00); stim.push_back(8'h0A);
        add_csum();
        start_load(1, n0);
        check("ready_after_start", bus.byte_ready, 1);
        check("stall_when_busy", bus.cpu_stall, 1);
        finish_load(1, n0, 0, 1'b1);
        check("single_word_value", wr_data_q.size() > 0 ? wr_data_q[0] : 32'h0, 32'h20A0000A);
        readback(1);

        // three words with byte_valid gaps
        clear_logs();
        rdy_in_write = 0;
        gen_stim(3);
        start_load(3, n0);
        finish_load(3, n0, 3, 1'b0);
        check("ready_low_in_write", rdy_in_write, 0);
        readback(3);

        // illegal counts, then a legal start clears error
        bus.start = 1'b1; bus.word_count = AW'(0);
        tick();
        bus.start = 1'b0;
        check("cnt0_error", bus.error, 1);
        check("cnt0_idle", bus.busy, 0);
        check("cnt0_stall", bus.cpu_stall, 0);
        bus.start = 1'b1; bus.word_count = AW'(SIZE + 1);
        tick();
        bus.start = 1'b0;
        check("cnt111_error", bus.error, 1);
        check("cnt111_idle", bus.busy, 0);
        check("cnt111_stall", bus.cpu_stall, 0);
        clear_logs();
        gen_stim(2);
        start_load(2, n0);
        check("legal_clears_error", bus.error, 0);
        check("legal_busy", bus.busy, 1);
        finish_load(2, n0, 1, 1'b0);

        // maximum count is accepted
        clear_logs();
        gen_stim(SIZE);
        start_load(SIZE, n0);
        check("max_count_busy", bus.busy, 1);
        check("max_count_error", bus.error, 0);
        finish_load(SIZE, n0, 0, 1'b1);
        readback(SIZE);

        // start while busy is ignored
        clear_logs();
        gen_stim(2);
        start_load(2, n0);
        bus.start = 1'b1; bus.word_count = AW'(7);
        tick();
        bus.start = 1'b0;
        finish_load(2, n0, 1, 1'b0);

        // randomized loads
        for (int t = 0; t < 4; t++) begin
            k = int'($urandom_range(6, 1));
            clear_logs();
            gen_stim(k);
            start_load(k, n0);
            finish_load(k, n0, int'($urandom_range(2, 0)), 1'b0);
            readback(k);
        end

        // reset after two of four words
        clear_logs();
        gen_stim(4);
        start_load(4, n0);
        send_bytes(9, 1);
        check("pre_reset_writes", wr_addr_q.size(), 2);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        #2 rst_n = 1'b1;
        tick();
        bus.cpu_address = AW'(0);
        #1;
        check("kept_word0", bus.cpu_instruction, exp_word(0));
        bus.cpu_address = AW'(1);
        #1;
        check("kept_word1", bus.cpu_instruction, exp_word(1));

`ifdef LOADER_CHECKSUM_EN
        // good checksum
        clear_logs();
        stim.delete();
        stim.push_back(8'h01); stim.push_back(8'h02); stim.push_back(8'h03); stim.push_back(8'h04);
        stim.push_back(8'h04);
        start_load(1, n0);
        finish_load(1, n0, 0, 1'b1);
        check("csum_good_error", bus.error, 0);

        // bad checksum
        begin
            int dones;
            clear_logs();
            stim[4] = 8'h05;
            start_load(1, n0);
            send_bytes(5, 0);
            dones = 0;
            for (int i = 0; i < 8; i++) begin
                if (bus.done) dones++;
                tick();
            end
            check("csum_bad_no_done", dones, 0);
            check("csum_bad_error", bus.error, 1);
            check("csum_bad_idle", bus.busy, 0);
            check("csum_bad_mem_kept", wr_addr_q.size(), 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
